framing_tx_arbiter: RTL and testbench
=====================================

Name: framing_tx_arbiter

Overview:
- Shares the single tx_frame input of the framing block between NUM_PORTS independent frame sources.
- Grants are round-robin and frame-atomic: once a source is granted, it keeps the channel until its tlast beat.
- Optionally prepends one header byte carrying the granted port index, so the far end can demultiplex frames.
- Sits directly upstream of the framing block's tx_frame_* inputs.

Parameters:
- NUM_PORTS, 4, number of requesting frame sources; legal range 1..256.
- ID_HEADER, 1, 1 = insert the port-index byte before each frame; 0 = pass frames through unmodified.
- IDW, derived as max(1, clog2(NUM_PORTS)), width of cur_port. Not user-overridable.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; asynchronous, active-low.
- s_tvalid  in  NUM_PORTS  per-source frame beat valid.
- s_tready  out  NUM_PORTS  per-source ready.
- s_tdata  in  8*NUM_PORTS  per-source byte; port i occupies bits [8i+7:8i].
- s_tlast  in  NUM_PORTS  per-source end-of-frame.
- m_tvalid  out  1  to framing tx_frame_tvalid.
- m_tready  in  1  from framing tx_frame_tready.
- m_tdata  out  8  to framing tx_frame_tdata.
- m_tlast  out  1  to framing tx_frame_tlast.
- busy  out  1  high while a frame is granted (HEADER or DATA state).
- cur_port  out  IDW  index of the granted port; holds the last grant value while idle.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr_ptr=0, grant=0.
  - m_tvalid=0, s_tready=0, busy=0, cur_port=0.
- States: IDLE, HEADER, DATA.
- IDLE:
  - m_tvalid=0, all s_tready=0.
  - Search s_tvalid starting at rr_ptr, wrapping modulo NUM_PORTS; the first set bit wins.
  - On a hit: register grant, then go to HEADER if ID_HEADER=1, else DATA.
  - The grant decision is registered, so there is no combinational path from s_tvalid to m_*. Exactly one idle cycle is spent per frame.
- HEADER:
  - m_tvalid=1, m_tdata=grant zero-extended to 8 bits, m_tlast=0, all s_tready=0.
  - Go to DATA when m_tvalid && m_tready.
  - The header byte is never the last beat.
- DATA (zero-latency pass-through of the granted port):
  - m_tvalid=s_tvalid[grant], m_tdata=s_tdata[grant], m_tlast=s_tlast[grant].
  - s_tready[grant]=m_tready; every other s_tready=0.
  - On a beat with s_tvalid[grant] && m_tready && s_tlast[grant]: go to IDLE and set rr_ptr=(grant+1) mod NUM_PORTS.
- Lock rules:
  - If the granted source drops tvalid mid-frame, the grant is held indefinitely.
  - There is no timeout and no pre-emption.
  - Requests from other ports are ignored until the tlast beat.
- m_tvalid must not drop while m_tready=0. The header beat is held stable by construction. In DATA, stability is inherited from the source's AXI-Stream compliance.
- Simultaneous requests: all ports valid with rr_ptr=0 gives grant order 0,1,2,...,NUM_PORTS-1, then 0 again.
- Single requester: port k re-granted back-to-back, with one IDLE cycle (plus the header beat) between frames.
- NUM_PORTS=1: rr_ptr is constant 0 and the header byte is always 0x00.
- Reset mid-frame: the frame is truncated with no tlast emitted. The downstream framing block's reset is expected to be the same aresetn.
- busy = (state != IDLE). cur_port = grant.

Decomposition:
- Shared package framing_pkg:
  - state enum (IDLE/HEADER/DATA).
  - function clog2_min1 for IDW.
  - constant HDR_WIDTH=8.
- Sub-module framing_rr_arbiter:
  - Holds rr_ptr; takes req vector plus an advance strobe and last-grant index.
  - Outputs the one-hot/encoded winner combinationally.
  - Parameterised by NUM_PORTS.

Test Plan:
- Reset, then port 2 sends 3-byte frame {0x11,0x22,0x33(tlast)}, m_tready=1 -> m_* sequence 0x02, 0x11, 0x22, 0x33 with tlast on 0x33 only; busy high for 4 cycles; cur_port=2.
- All 4 ports hold valid single-byte frames continuously, ID_HEADER=1 -> headers appear in order 0x00, 0x01, 0x02, 0x03, 0x00; each port sees exactly one s_tready pulse per its frame.
- Port 1 mid-frame drops s_tvalid for 5 cycles while port 0 requests -> m_tvalid=0 for those 5 cycles; port 0 is not granted until after port 1's tlast beat.
- m_tready toggles randomly (50%) during header and data -> m_tdata/m_tlast are stable while m_tvalid && !m_tready; no beats lost or duplicated against a scoreboard.
- ID_HEADER=0, port 3 sends {0xAA(tlast)} then {0xBB(tlast)} -> output 0xAA(tlast), one idle cycle, 0xBB(tlast); no header bytes.
- aresetn asserted mid-DATA after 2 of 4 bytes -> m_tvalid=0 and all s_tready=0 immediately (asynchronously); after release, state=IDLE and next grant starts from port 0.

Source files
------------

// File: rtl/framing_pkg.sv
// Shared types and helpers for the framing transmit-side blocks.
// Holds the arbiter FSM encoding and the index-width helper.
package framing_pkg;

    localparam int HDR_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_t;

    // A one-port arbiter still needs a 1-bit index signal.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/framing_rr_arbiter.sv
// Round-robin request picker: searches req starting at rr_ptr, wrapping.
// rr_ptr moves to the port after last_grant whenever advance is strobed.
module framing_rr_arbiter
    import framing_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic [NUM_PORTS-1:0]                req,
    input  logic                                advance,
    input  logic [clog2_min1(NUM_PORTS)-1:0]    last_grant,
    output logic                                hit,
    output logic [clog2_min1(NUM_PORTS)-1:0]    winner
);

    localparam int IDW = clog2_min1(NUM_PORTS);

    logic [IDW-1:0] rr_ptr;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rr_ptr <= '0;
        end else if (advance) begin
            if (last_grant == IDW'(NUM_PORTS - 1))
                rr_ptr <= '0;
            else
                rr_ptr <= last_grant + IDW'(1);
        end
    end

    // First set request at or after rr_ptr, modulo NUM_PORTS.
    always_comb begin
        int idx;
        hit    = 1'b0;
        winner = '0;
        idx    = 0;
        for (int off = 0; off < NUM_PORTS; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NUM_PORTS)
                idx = idx - NUM_PORTS;
            if (!hit && req[idx]) begin
                hit    = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/framing_tx_arbiter.sv
// Frame-atomic round-robin mux of NUM_PORTS byte streams onto the framing
// block's tx_frame input, optionally prefixing each frame with its port index.
module framing_tx_arbiter
    import framing_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ID_HEADER = 1
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic [NUM_PORTS-1:0]                s_tvalid,
    output logic [NUM_PORTS-1:0]                s_tready,
    input  logic [8*NUM_PORTS-1:0]              s_tdata,
    input  logic [NUM_PORTS-1:0]                s_tlast,
    output logic                                m_tvalid,
    input  logic                                m_tready,
    output logic [HDR_WIDTH-1:0]                m_tdata,
    output logic                                m_tlast,
    output logic                                busy,
    output logic [clog2_min1(NUM_PORTS)-1:0]    cur_port
);

    localparam int IDW = clog2_min1(NUM_PORTS);

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] grant;
    logic           hit;
    logic [IDW-1:0] winner;
    logic           advance;

    logic           sel_valid;
    logic [7:0]     sel_data;
    logic           sel_last;

    framing_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .req        (s_tvalid),
        .advance    (advance),
        .last_grant (grant),
        .hit        (hit),
        .winner     (winner)
    );

    // Explicit compare-mux keeps non-power-of-two port counts in range.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = 8'h00;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant == IDW'(i)) begin
                sel_valid = s_tvalid[i];
                sel_data  = s_tdata[8*i +: 8];
                sel_last  = s_tlast[i];
            end
        end
    end

    assign advance = (state == ST_DATA) && sel_valid && m_tready && sel_last;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
            grant <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && hit)
                grant <= winner;
        end
    end

    always_comb begin
        state_nxt = state;
        m_tvalid  = 1'b0;
        m_tdata   = '0;
        m_tlast   = 1'b0;
        s_tready  = '0;
        case (state)
            ST_IDLE: begin
                if (hit)
                    state_nxt = (ID_HEADER != 0) ? ST_HEADER : ST_DATA;
            end
            ST_HEADER: begin
                m_tvalid = 1'b1;
                m_tdata  = HDR_WIDTH'(grant);
                if (m_tready)
                    state_nxt = ST_DATA;
            end
            ST_DATA: begin
                m_tvalid = sel_valid;
                m_tdata  = sel_data;
                m_tlast  = sel_last;
                for (int i = 0; i < NUM_PORTS; i++)
                    s_tready[i] = m_tready && (grant == IDW'(i));
                if (advance)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy     = (state != ST_IDLE);
    assign cur_port = grant;

endmodule

// File: tb/tb_framing_tx_arbiter.sv
// Directed bench for framing_tx_arbiter: a per-cycle reference model of the
// grant/header/pass-through rules plus hand-computed output beat streams.
module tb_framing_tx_arbiter;

    logic        aclk;
    logic        aresetn;
    logic [3:0]  s_tvalid, s_tready, s_tlast;
    logic [31:0] s_tdata;
    logic        m_tvalid, m_tready, m_tlast, busy;
    logic [7:0]  m_tdata;
    logic [1:0]  cur_port;

    logic [3:0]  s2_tvalid, s2_tready, s2_tlast;
    logic [31:0] s2_tdata;
    logic        m2_tvalid, m2_tready, m2_tlast, busy2;
    logic [7:0]  m2_tdata;
    logic [1:0]  cur2;

    framing_tx_arbiter #(.NUM_PORTS(4), .ID_HEADER(1)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .busy(busy), .cur_port(cur_port)
    );

    framing_tx_arbiter #(.NUM_PORTS(4), .ID_HEADER(0)) dut_nh (
        .aclk(aclk), .aresetn(aresetn),
        .s_tvalid(s2_tvalid), .s_tready(s2_tready), .s_tdata(s2_tdata), .s_tlast(s2_tlast),
        .m_tvalid(m2_tvalid), .m_tready(m2_tready), .m_tdata(m2_tdata), .m_tlast(m2_tlast),
        .busy(busy2), .cur_port(cur2)
    );

    // clock / reset
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // source queues: {gap[3:0], last, data[7:0]}; gap = idle cycles before the beat
    logic [12:0] src_q[4][$];
    logic [8:0]  q2[$];
    logic [8:0]  exp_q[$];
    logic [8:0]  got_q[$];
    logic [9:0]  log2[$];
    logic        log2_en;

    int checks, failures;
    int mst, mport, mptr;
    int rdy_mode;
    int rdy_cnt[4];
    int hs_cnt[4];
    int busy_cnt, stall_cnt;
    logic       prev_hold;
    logic [8:0] prev_beat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, compare just before posedge, update model.
    task automatic step();
        logic [12:0] h;
        logic [3:0]  sv;
        logic        exp_v, done;
        logic [8:0]  exp_b;
        bit          found;
        @(negedge aclk);
        for (int p = 0; p < 4; p++) begin
            sv[p] = 1'b0;
            s_tdata[8*p +: 8] = 8'h00;
            s_tlast[p] = 1'b0;
            if (src_q[p].size() > 0) begin
                h = src_q[p][0];
                if (h[12:9] == 4'd0) begin
                    sv[p] = 1'b1;
                    s_tdata[8*p +: 8] = h[7:0];
                    s_tlast[p] = h[8];
                end
            end
        end
        s_tvalid = sv;
        m_tready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        s2_tvalid = {q2.size() > 0, 3'b000};
        s2_tdata  = (q2.size() > 0) ? {q2[0][7:0], 24'h0} : 32'h0;
        s2_tlast  = (q2.size() > 0) ? {q2[0][8], 3'b000} : 4'h0;
        m2_tready = 1'b1;
        #4;
        // compare against the model
        exp_v = (mst == 1) || (mst == 2 && sv[mport]);
        check("m_tvalid", 32'(m_tvalid), 32'(exp_v));
        check("s_tready", 32'(s_tready), (mst == 2 && m_tready) ? (32'd1 << mport) : 32'd0);
        check("busy", 32'(busy), 32'(mst != 0));
        check("cur_port", 32'(cur_port), 32'(mport));
        if (exp_v) begin
            if (mst == 1) exp_b = {1'b0, 8'(mport)};
            else          exp_b = src_q[mport][0][8:0];
            check("m_beat", 32'({m_tlast, m_tdata}), 32'(exp_b));
        end
        if (prev_hold)
            check("m_hold", 32'({m_tvalid, m_tlast, m_tdata}), 32'({1'b1, prev_beat}));
        prev_hold = m_tvalid && !m_tready;
        prev_beat = {m_tlast, m_tdata};
        // model next state, from values before the pops
        done = (mst == 2) && sv[mport] && m_tready && src_q[mport][0][8];
        if (mst == 0) begin
            found = 1'b0;
            for (int off = 0; off < 4; off++) begin
                if (!found && sv[(mptr + off) % 4]) begin
                    found = 1'b1;
                    mport = (mptr + off) % 4;
                    mst   = 1;
                end
            end
        end else if (mst == 1) begin
            if (m_tready) mst = 2;
        end else if (done) begin
            mst  = 0;
            mptr = (mport + 1) % 4;
        end
        // scoreboard capture and source pops
        if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
        if (busy) busy_cnt++;
        if (busy && !m_tvalid) stall_cnt++;
        for (int p = 0; p < 4; p++) begin
            if (s_tready[p]) rdy_cnt[p]++;
            if (sv[p] && s_tready[p]) begin
                void'(src_q[p].pop_front());
                hs_cnt[p]++;
            end else if (src_q[p].size() > 0 && src_q[p][0][12:9] != 4'd0) begin
                h = src_q[p].pop_front();
                h[12:9] = h[12:9] - 4'd1;
                src_q[p].push_front(h);
            end
        end
        if (log2_en) log2.push_back({m2_tvalid, m2_tlast, m2_tdata});
        if (s2_tvalid[3] && s2_tready[3]) void'(q2.pop_front());
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size() > 0
                || mst != 0) && n < budget) begin
            step();
            n++;
        end
        check({name, "_drain"}, 32'(n < budget), 32'd1);
        step();
    endtask

    task automatic do_reset(input string name);
        @(posedge aclk);
        #2 aresetn = 1'b0;
        #1;
        check({name, "_rst_mvalid"}, 32'(m_tvalid), 32'd0);
        check({name, "_rst_sready"}, 32'(s_tready), 32'd0);
        check({name, "_rst_busy"}, 32'(busy), 32'd0);
        check({name, "_rst_cur"}, 32'(cur_port), 32'd0);
        for (int p = 0; p < 4; p++) src_q[p].delete();
        q2.delete();
        s_tvalid = 4'h0;
        s2_tvalid = 4'h0;
        mst = 0; mport = 0; mptr = 0;
        prev_hold = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic compare_stream(input string name);
        check({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size())
                check($sformatf("%s_beat%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic push(input int p, input logic [3:0] gap, input logic last, input logic [7:0] d);
        src_q[p].push_back({gap, last, d});
    endtask

    initial begin
        logic [9:0] exp5[5];
        int n;
        checks = 0; failures = 0;
        mst = 0; mport = 0; mptr = 0;
        rdy_mode = 0; log2_en = 1'b0; prev_hold = 1'b0;
        busy_cnt = 0; stall_cnt = 0;
        for (int p = 0; p < 4; p++) begin rdy_cnt[p] = 0; hs_cnt[p] = 0; end
        s_tvalid = 4'h0; s_tdata = 32'h0; s_tlast = 4'h0; m_tready = 1'b1;
        s2_tvalid = 4'h0; s2_tdata = 32'h0; s2_tlast = 4'h0; m2_tready = 1'b1;
        aresetn = 1'b0;
        #2;
        check("reset_mvalid", 32'(m_tvalid), 32'd0);
        check("reset_sready", 32'(s_tready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_cur", 32'(cur_port), 32'd0);
        check("reset_m2valid", 32'(m2_tvalid), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;

        // T1: port 2 sends a 3-byte frame
        push(2, 0, 0, 8'h11); push(2, 0, 0, 8'h22); push(2, 0, 1, 8'h33);
        busy_cnt = 0;
        drain("t1", 50);
        exp_q = '{9'h002, 9'h011, 9'h022, 9'h133};
        compare_stream("t1");
        check("t1_busy_cycles", 32'(busy_cnt), 32'd4);
        check("t1_cur_port", 32'(cur_port), 32'd2);

        // T2: all ports request at once from rr_ptr=0
        do_reset("t2");
        for (int p = 0; p < 4; p++) begin
            push(p, 0, 1, 8'hA0 + 8'(p));
            rdy_cnt[p] = 0;
        end
        push(0, 0, 1, 8'hB0);
        drain("t2", 80);
        exp_q = '{9'h000, 9'h1A0, 9'h001, 9'h1A1, 9'h002, 9'h1A2, 9'h003, 9'h1A3, 9'h000, 9'h1B0};
        compare_stream("t2");
        check("t2_rdy0", 32'(rdy_cnt[0]), 32'd2);
        check("t2_rdy1", 32'(rdy_cnt[1]), 32'd1);
        check("t2_rdy2", 32'(rdy_cnt[2]), 32'd1);
        check("t2_rdy3", 32'(rdy_cnt[3]), 32'd1);

        // T3: granted port 1 stalls 5 cycles mid-frame while port 0 waits
        push(1, 0, 0, 8'h41); push(1, 0, 0, 8'h42); push(1, 5, 0, 8'h43); push(1, 0, 1, 8'h44);
        push(0, 0, 1, 8'h50);
        stall_cnt = 0;
        drain("t3", 80);
        exp_q = '{9'h001, 9'h041, 9'h042, 9'h043, 9'h144, 9'h000, 9'h150};
        compare_stream("t3");
        check("t3_stall_cycles", 32'(stall_cnt), 32'd5);

        // T4: random downstream backpressure
        rdy_mode = 1;
        push(2, 0, 0, 8'h61); push(2, 0, 1, 8'h62);
        push(3, 0, 1, 8'h71);
        push(0, 0, 0, 8'h81); push(0, 2, 1, 8'h82);
        drain("t4", 400);
        rdy_mode = 0;
        exp_q = '{9'h002, 9'h061, 9'h162, 9'h003, 9'h171, 9'h000, 9'h081, 9'h182};
        compare_stream("t4");

        // T5: no-header instance, port 3 sends two single-byte frames
        log2.delete();
        log2_en = 1'b1;
        q2.push_back(9'h1AA); q2.push_back(9'h1BB);
        for (int i = 0; i < 5; i++) step();
        log2_en = 1'b0;
        exp5 = '{10'h000, 10'h3AA, 10'h000, 10'h3BB, 10'h000};
        check("t5_len", 32'(log2.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < log2.size()) begin
                check($sformatf("t5_vld%0d", i), 32'(log2[i][9]), 32'(exp5[i][9]));
                if (exp5[i][9])
                    check($sformatf("t5_beat%0d", i), 32'(log2[i][8:0]), 32'(exp5[i][8:0]));
            end
        end

        // T6: reset in the middle of a frame, then grant restarts at port 0
        push(1, 0, 1, 8'hC1);
        drain("t6a", 50);
        got_q.delete();
        for (int p = 0; p < 4; p++) hs_cnt[p] = 0;
        push(2, 0, 0, 8'hC2); push(2, 0, 0, 8'hC3); push(2, 0, 0, 8'hC4); push(2, 0, 1, 8'hC5);
        n = 0;
        while (hs_cnt[2] < 2 && n < 50) begin
            step();
            n++;
        end
        check("t6_two_beats", 32'(hs_cnt[2]), 32'd2);
        #1;
        check("t6_busy_pre", 32'(busy), 32'd1);
        do_reset("t6");
        got_q.delete();
        push(1, 0, 1, 8'hD1);
        push(3, 0, 1, 8'hD3);
        drain("t6b", 50);
        exp_q = '{9'h001, 9'h1D1, 9'h003, 9'h1D3};
        compare_stream("t6");
        check("t6_cur_port", 32'(cur_port), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
